crosshair_pos_filter: RTL and testbench
=======================================

// Module: crosshair_pos_filter
//
// PURPOSE
// Conditions the raw aim coordinates from the mouse/gun interface before the crosshair draw stage.
// - Clamps each coordinate to the visible area.
// - Smooths each axis with a 2^AVG_SHIFT-sample moving average.
// - Latches the result only at the start of vertical blanking, so the crosshair never tears mid-frame.
// - Tracks source activity and drops pos_valid when no samples arrive for TIMEOUT_FRAMES frames.
//
// PARAMETERS
// H_ACTIVE        1024  visible width in pixels; x is clamped to [0, H_ACTIVE-1]
// V_ACTIVE        768   visible height in lines; y is clamped to [0, V_ACTIVE-1]
// AVG_SHIFT       2     log2 of the averaging depth (depth = 4); legal range 0..4
// TIMEOUT_FRAMES  30    frames without a sample before the source is declared lost; legal range 1..255
//
// PORTS
// clk        in   1   pixel clock
// rst        in   1   synchronous, active-high reset
// raw_x      in   12  unsigned raw x coordinate; qualified by raw_valid
// raw_y      in   12  unsigned raw y coordinate; qualified by raw_valid
// raw_valid  in   1   one-cycle strobe: raw_x/raw_y hold a new sample
// vblnk      in   1   vertical blank from the VGA timing stream
// xpos       out  12  filtered x position, stable for a whole frame
// ypos       out  12  filtered y position, stable for a whole frame
// pos_valid  out  1   1 = source active and xpos/ypos meaningful
//
// BEHAVIOUR
// Reset values
// - xpos = H_ACTIVE/2, ypos = V_ACTIVE/2, pos_valid = 0.
// - State LOST; ring buffers, sums, frame counter and seen flag all cleared.
// Sample pipeline (applies to both axes)
// - Cycle N: raw_valid=1 is captured, values clamped (any value >= limit becomes limit-1), result registered.
// - Cycle N+1, state TRACK: clamped sample written to the ring at wr_ptr.
// - Same cycle: sum <= sum + new - ring[wr_ptr]; wr_ptr increments and wraps modulo 2^AVG_SHIFT.
// - Sum width is 12+AVG_SHIFT bits, unsigned, never overflows.
// - avg = sum >> AVG_SHIFT, truncating.
// - Back-to-back raw_valid on every cycle is legal; every sample enters the average.
// State machine
// - LOST -> TRACK on the first clamped sample.
// - On that transition every ring entry is preloaded with the sample and sum = sample << AVG_SHIFT.
// - Result: no drift toward 0 after connect.
// - TRACK -> LOST when frame_cnt reaches TIMEOUT_FRAMES on a frame edge.
// - Ring contents are kept but irrelevant, since the next connect preloads them.
// Frame edge
// - fe = vblnk & ~vblnk_d, where vblnk_d is vblnk registered once.
// - On fe in TRACK: xpos <= avg_x, ypos <= avg_y, pos_valid <= 1. Visible the cycle after fe.
// - On fe in LOST: xpos/ypos hold, pos_valid <= 0.
// - xpos/ypos change only on fe, never elsewhere.
// Activity timeout
// - seen flag sets on any clamped sample and clears on fe.
// - On fe with seen=1: frame_cnt <= 0.
// - On fe with seen=0: frame_cnt <= frame_cnt+1, saturating.
// - When the increment reaches TIMEOUT_FRAMES: go to LOST on the same edge and drop pos_valid with it.
// Simultaneous events
// - Sample sum update coinciding with fe: the latch uses the pre-update avg; the sample counts in the next frame.
// - Sample arriving in the fe cycle: sets seen for the new frame.
// - rst mid-operation: all state returns to reset values on the next edge; no partial sums survive.
//
// TESTING
// 1. Reset, then no samples -> xpos=512, ypos=384, pos_valid=0 held across 3 frames.
// 2. One sample (300,200), then fe -> xpos=300, ypos=200, pos_valid=1 the cycle after fe (preload check).
// 3. TRACK at (300,200), then samples x=400,400,400,400 -> sum steps give avg 325,350,375,400.
//    Only the value present at fe is latched; nothing changes mid-frame.
// 4. Sample (4000,4095) -> latched xpos=1023, ypos=767. Sample (0,0) -> 0,0.
// 5. Stop samples after connect -> pos_valid falls exactly at the 30th fe without samples; xpos/ypos hold.
//    A sample arriving at the 29th frame resets the count and pos_valid stays 1.
// 6. Assert rst with sum nonzero and mid-frame -> reset values next cycle.
//    First sample after reset is preloaded and latches exactly at the following fe.

Source files
------------

// File: rtl/crosshair_pos_filter.sv
// Aim-coordinate conditioner: clamps raw x/y to the visible area, averages each axis,
// latches the result once per frame at vblank entry and tracks whether the source is alive.
module crosshair_pos_filter #(
  parameter int unsigned H_ACTIVE       = 1024,
  parameter int unsigned V_ACTIVE       = 768,
  parameter int unsigned AVG_SHIFT      = 2,
  parameter int unsigned TIMEOUT_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] raw_x,
  input  logic [11:0] raw_y,
  input  logic        raw_valid,
  input  logic        vblnk,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        pos_valid
);

  localparam int unsigned Depth = 1 << AVG_SHIFT;
  localparam int unsigned SumW  = 12 + AVG_SHIFT;
  localparam int unsigned PtrW  = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;

  localparam logic [11:0] XMax     = 12'(H_ACTIVE - 1);
  localparam logic [11:0] YMax     = 12'(V_ACTIVE - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
  localparam logic [7:0]  Timeout  = 8'(TIMEOUT_FRAMES);

  typedef enum logic {StLost, StTrack} state_e;

  state_e            state;
  logic              vblnk_d;
  logic              s_valid;
  logic [11:0]       s_x, s_y;
  logic [11:0]       ring_x [Depth];
  logic [11:0]       ring_y [Depth];
  logic [SumW-1:0]   sum_x, sum_y;
  logic [PtrW-1:0]   wr_ptr;
  logic [7:0]        frame_cnt;
  logic              seen;

  logic              fe;
  logic [11:0]       clamp_x, clamp_y;
  logic [11:0]       avg_x, avg_y;
  logic [7:0]        cnt_inc;
  logic              timeout;

  always_comb begin
    fe      = vblnk & ~vblnk_d;
    clamp_x = (raw_x > XMax) ? XMax : raw_x;
    clamp_y = (raw_y > YMax) ? YMax : raw_y;
    avg_x   = 12'(sum_x >> AVG_SHIFT);
    avg_y   = 12'(sum_y >> AVG_SHIFT);
    cnt_inc = (frame_cnt == 8'hff) ? frame_cnt : frame_cnt + 8'd1;
    timeout = (state == StTrack) && fe && !seen && (cnt_inc == Timeout);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StLost;
      vblnk_d   <= 1'b0;
      s_valid   <= 1'b0;
      s_x       <= '0;
      s_y       <= '0;
      sum_x     <= '0;
      sum_y     <= '0;
      wr_ptr    <= '0;
      frame_cnt <= '0;
      seen      <= 1'b0;
      xpos      <= 12'(H_ACTIVE / 2);
      ypos      <= 12'(V_ACTIVE / 2);
      pos_valid <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) begin
        ring_x[i] <= '0;
        ring_y[i] <= '0;
      end
    end else begin
      vblnk_d <= vblnk;
      s_valid <= raw_valid;
      s_x     <= clamp_x;
      s_y     <= clamp_y;

      // A sample still in the pipeline at the frame edge belongs to the new frame.
      if (fe) begin
        seen      <= s_valid;
        frame_cnt <= seen ? 8'd0 : cnt_inc;
      end else if (s_valid) begin
        seen <= 1'b1;
      end

      unique case (state)
        StLost: begin
          if (fe) pos_valid <= 1'b0;
          // Preload the whole ring so the average starts at the first sample.
          if (s_valid) begin
            state     <= StTrack;
            sum_x     <= SumW'(s_x) << AVG_SHIFT;
            sum_y     <= SumW'(s_y) << AVG_SHIFT;
            wr_ptr    <= '0;
            frame_cnt <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
              ring_x[i] <= s_x;
              ring_y[i] <= s_y;
            end
          end
        end
        StTrack: begin
          if (timeout) begin
            state     <= StLost;
            pos_valid <= 1'b0;
          end else if (fe) begin
            // avg reflects the sum before any coincident sample update.
            xpos      <= avg_x;
            ypos      <= avg_y;
            pos_valid <= 1'b1;
          end
          if (s_valid) begin
            ring_x[wr_ptr] <= s_x;
            ring_y[wr_ptr] <= s_y;
            sum_x  <= sum_x + SumW'(s_x) - SumW'(ring_x[wr_ptr]);
            sum_y  <= sum_y + SumW'(s_y) - SumW'(ring_y[wr_ptr]);
            wr_ptr <= (wr_ptr == PtrLast) ? '0 : wr_ptr + 1'b1;
          end
        end
        default: state <= StLost;
      endcase
    end
  end

endmodule

// File: tb/tb_crosshair_pos_filter.sv
// Directed bench for crosshair_pos_filter: vector table for clamping plus hand sequences
// for preload, averaging steps, timeout, reset and sample/frame-edge coincidence.
module tb_crosshair_pos_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] raw_x, raw_y;
  logic        raw_valid;
  logic        vblnk;
  logic [11:0] xpos, ypos;
  logic        pos_valid;

  int errors = 0;
  int checks = 0;

  crosshair_pos_filter dut (
    .clk       (clk),
    .rst       (rst),
    .raw_x     (raw_x),
    .raw_y     (raw_y),
    .raw_valid (raw_valid),
    .vblnk     (vblnk),
    .xpos      (xpos),
    .ypos      (ypos),
    .pos_valid (pos_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] ex;
    logic [11:0] ey;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int ex, input int ey, input int ev);
    chk({tag, ".xpos"}, xpos, 12'(ex));
    chk({tag, ".ypos"}, ypos, 12'(ey));
    chk({tag, ".pos_valid"}, {11'd0, pos_valid}, 12'(ev));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sample(input int x, input int y);
    raw_x     = 12'(x);
    raw_y     = 12'(y);
    raw_valid = 1'b1;
    @(negedge clk);
    raw_valid = 1'b0;
    idle(2);
  endtask

  // Outputs are checked two negedges after vblnk rises, i.e. after the latching edge.
  task automatic frame();
    vblnk = 1'b1;
    idle(2);
    vblnk = 1'b0;
    idle(3);
  endtask

  initial begin
    vecs[0] = '{x: 12'd4000, y: 12'd4095, ex: 12'd1023, ey: 12'd767};
    vecs[1] = '{x: 12'd0,    y: 12'd0,    ex: 12'd0,    ey: 12'd0};
    vecs[2] = '{x: 12'd1024, y: 12'd768,  ex: 12'd1023, ey: 12'd767};
    vecs[3] = '{x: 12'd1023, y: 12'd767,  ex: 12'd1023, ey: 12'd767};
    vecs[4] = '{x: 12'd512,  y: 12'd100,  ex: 12'd512,  ey: 12'd100};
    vecs[5] = '{x: 12'd100,  y: 12'd700,  ex: 12'd100,  ey: 12'd700};

    rst = 1'b1; raw_x = '0; raw_y = '0; raw_valid = 1'b0; vblnk = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);

    // 1: reset values, held across frames with no source.
    check_out("reset", 512, 384, 0);
    for (int i = 0; i < 3; i++) frame();
    check_out("idle_frames", 512, 384, 0);

    // 2: first sample preloads; visible only after the frame edge.
    sample(300, 200);
    check_out("pre_fe", 512, 384, 0);
    vblnk = 1'b1;
    @(negedge clk);
    check_out("connect", 300, 200, 1);
    vblnk = 1'b0;
    idle(3);

    // 3: averaging steps, one sample per frame; nothing moves mid-frame.
    sample(400, 200);
    check_out("midframe", 300, 200, 1);
    frame();
    check_out("avg1", 325, 200, 1);
    sample(400, 200); frame(); check_out("avg2", 350, 200, 1);
    sample(400, 200); frame(); check_out("avg3", 375, 200, 1);
    sample(400, 200); frame(); check_out("avg4", 400, 200, 1);

    // 4: clamping table; four samples fill the ring so the average equals the clamped value.
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 4; k++) sample(vecs[v].x, vecs[v].y);
      frame();
      check_out($sformatf("vec%0d", v), vecs[v].ex, vecs[v].ey, 1);
    end

    // 5: timeout; a sample in the 29th frame restarts the count.
    for (int i = 0; i < 28; i++) frame();
    sample(100, 700);
    frame();
    check_out("refresh29", 100, 700, 1);
    for (int i = 0; i < 29; i++) frame();
    check_out("empty29", 100, 700, 1);
    frame();
    check_out("timeout30", 100, 700, 0);
    frame();
    check_out("lost_hold", 100, 700, 0);

    // 6: reset mid-operation with a nonzero sum.
    sample(800, 600);
    sample(100, 100);
    rst = 1'b1;
    @(negedge clk);
    check_out("mid_rst", 512, 384, 0);
    rst = 1'b0;
    idle(2);
    check_out("post_rst", 512, 384, 0);
    sample(50, 60);
    frame();
    check_out("rst_connect", 50, 60, 1);

    // Sample update on the frame edge itself: latch uses the old average.
    raw_x = 12'd130; raw_y = 12'd60; raw_valid = 1'b1;
    @(negedge clk);
    raw_valid = 1'b0;
    vblnk = 1'b1;
    @(negedge clk);
    check_out("coincide", 50, 60, 1);
    vblnk = 1'b0;
    idle(3);
    frame();
    check_out("coincide_next", 70, 60, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
